axi_rw_arbiter: RTL and testbench

//  Schedules the single AXI4 port between the burst write master and the burst read master.

---
 rtl/axi_rw_arbiter_pkg.sv | 26 ++
 rtl/axi_burst_addr_gen.sv | 56 +++++
 rtl/axi_rw_arbiter.sv | 123 ++++++++++++
 tb/tb_axi_rw_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rw_arbiter_pkg.sv
// Shared definitions for the AXI read/write burst arbiter: FSM encodings,
// grant encoding, width constants and the per-burst address increment.
package axi_rw_arbiter_pkg;

  localparam int AXI_ADDR_W = 30;
  localparam int AXLEN_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_START = 3'd1,
    ST_WR_BUSY  = 3'd2,
    ST_RD_START = 3'd3,
    ST_RD_BUSY  = 3'd4
  } arb_state_e;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_e;

  // Bytes covered by one burst of (len+1) beats.
  function automatic int burst_incr(input int len, input int beat_bytes);
    return (len + 1) * beat_bytes;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-direction burst address pointer: advances on done, wraps inside its
// region, and defers a clear that arrives while a burst is in flight.
module axi_burst_addr_gen
  import axi_rw_arbiter_pkg::*;
#(
  parameter int                ADDR_W   = AXI_ADDR_W,
  parameter int                INCR     = 2048,
  parameter logic [ADDR_W-1:0] BEG_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active_i,
  input  logic              clr_i,
  input  logic              done_i,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [ADDR_W+1:0] INCR_X = (ADDR_W+2)'(INCR);
  localparam logic [ADDR_W+1:0] END_X  = {2'b00, END_ADDR};

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pend_q, pend_d;
  logic [ADDR_W+1:0] nxt, nxt_end;
  logic [ADDR_W-1:0] adv;

  // The following burst must still fit below END_ADDR, otherwise rewind.
  assign nxt     = {2'b00, addr_q} + INCR_X;
  assign nxt_end = nxt + INCR_X;
  assign adv     = (nxt_end > END_X) ? BEG_ADDR : nxt[ADDR_W-1:0];

  always_comb begin
    addr_d = addr_q;
    pend_d = pend_q;
    if (done_i) begin
      addr_d = (clr_i || pend_q) ? BEG_ADDR : adv;
      pend_d = 1'b0;
    end else if (clr_i) begin
      if (active_i) pend_d = 1'b1;
      else          addr_d = BEG_ADDR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= BEG_ADDR;
      pend_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      pend_q <= pend_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/axi_rw_arbiter.sv
// Schedules one AXI4 port between the burst write and burst read masters.
// Round-robin by default; define RW_ARB_RD_PRIO_EN for fixed read priority.
module axi_rw_arbiter
  import axi_rw_arbiter_pkg::*;
#(
  parameter int                 ADDR_W      = AXI_ADDR_W,
  parameter logic [AXLEN_W-1:0] BURST_LEN   = 8'd255,
  parameter int                 BEAT_BYTES  = 8,
  parameter logic [ADDR_W-1:0]  WR_BEG_ADDR = 30'd0,
  parameter logic [ADDR_W-1:0]  WR_END_ADDR = 30'd1048576,
  parameter logic [ADDR_W-1:0]  RD_BEG_ADDR = 30'd0,
  parameter logic [ADDR_W-1:0]  RD_END_ADDR = 30'd1048576
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_req,
  input  logic               wr_addr_clr,
  input  logic               rd_req,
  input  logic               rd_addr_clr,
  input  logic               wr_ready,
  input  logic               wr_done,
  input  logic               rd_ready,
  input  logic               rd_done,
  output logic               wr_start,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [AXLEN_W-1:0] wr_len,
  output logic               rd_start,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [AXLEN_W-1:0] rd_len,
  output logic               busy
);

  localparam int INCR = burst_incr(int'(BURST_LEN), BEAT_BYTES);

  arb_state_e state_q, state_d;
  logic       wr_vld, rd_vld, pick_rd;
  logic       wr_start_q, rd_start_q;

  // A master that is not ready is simply not a candidate this cycle.
  assign wr_vld = wr_req & wr_ready;
  assign rd_vld = rd_req & rd_ready;

`ifdef RW_ARB_RD_PRIO_EN
  assign pick_rd = rd_vld;
`else
  grant_e last_grant_q, last_grant_d;

  assign pick_rd = rd_vld & (~wr_vld | (last_grant_q == GNT_WR));

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == ST_IDLE && (wr_vld || rd_vld))
      last_grant_d = pick_rd ? GNT_RD : GNT_WR;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= GNT_WR;
    else     last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_rd)     state_d = ST_RD_START;
        else if (wr_vld) state_d = ST_WR_START;
      end
      ST_WR_START: state_d = ST_WR_BUSY;
      ST_WR_BUSY:  if (wr_done) state_d = ST_IDLE;
      ST_RD_START: state_d = ST_RD_BUSY;
      ST_RD_BUSY:  if (rd_done) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_start_q <= (state_d == ST_WR_START);
      rd_start_q <= (state_d == ST_RD_START);
    end
  end

  axi_burst_addr_gen #(
    .ADDR_W   (ADDR_W),
    .INCR     (INCR),
    .BEG_ADDR (WR_BEG_ADDR),
    .END_ADDR (WR_END_ADDR)
  ) u_wr_addr (
    .clk      (clk),
    .rst      (rst),
    .active_i (state_q == ST_WR_START || state_q == ST_WR_BUSY),
    .clr_i    (wr_addr_clr),
    .done_i   (wr_done && state_q == ST_WR_BUSY),
    .addr_o   (wr_addr)
  );

  axi_burst_addr_gen #(
    .ADDR_W   (ADDR_W),
    .INCR     (INCR),
    .BEG_ADDR (RD_BEG_ADDR),
    .END_ADDR (RD_END_ADDR)
  ) u_rd_addr (
    .clk      (clk),
    .rst      (rst),
    .active_i (state_q == ST_RD_START || state_q == ST_RD_BUSY),
    .clr_i    (rd_addr_clr),
    .done_i   (rd_done && state_q == ST_RD_BUSY),
    .addr_o   (rd_addr)
  );

  assign wr_start = wr_start_q;
  assign rd_start = rd_start_q;
  assign wr_len   = BURST_LEN;
  assign rd_len   = BURST_LEN;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// Self-checking bench for axi_rw_arbiter (regions 0..8192, BURST_LEN=255).
module tb_axi_rw_arbiter;

  localparam int     ADDR_W = 30;
  localparam longint INCR   = 2048;
  localparam longint BEG    = 0;
  localparam longint ENDA   = 8192;
`ifdef RW_ARB_RD_PRIO_EN
  localparam bit RD_PRIO = 1'b1;
`else
  localparam bit RD_PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, wr_req, wr_addr_clr, rd_req, rd_addr_clr;
  logic wr_ready, wr_done, rd_ready, rd_done;
  logic wr_start, rd_start, busy;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [7:0] wr_len, rd_len;

  always #5 clk = ~clk;

  axi_rw_arbiter #(
    .ADDR_W(30), .BURST_LEN(8'd255), .BEAT_BYTES(8),
    .WR_BEG_ADDR(30'd0), .WR_END_ADDR(30'd8192),
    .RD_BEG_ADDR(30'd0), .RD_END_ADDR(30'd8192)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr_clr(wr_addr_clr),
    .rd_req(rd_req), .rd_addr_clr(rd_addr_clr),
    .wr_ready(wr_ready), .wr_done(wr_done),
    .rd_ready(rd_ready), .rd_done(rd_done),
    .wr_start(wr_start), .wr_addr(wr_addr), .wr_len(wr_len),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len),
    .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner -1 = nobody, 0 = write, 1 = read.
  int     m_owner = -1;
  bit     m_first = 1'b0;
  int     m_last  = 0;
  longint m_wptr  = BEG;
  longint m_rptr  = BEG;
  bit     m_wpend = 1'b0;
  bit     m_rpend = 1'b0;

  function automatic longint advance(input longint p);
    longint n;
    n = p + INCR;
    return (n + INCR > ENDA) ? BEG : n;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_update();
    bit wv, rv, wdn, rdn;
    int g;
    if (rst) begin
      m_owner = -1; m_first = 1'b0; m_last = 0;
      m_wptr = BEG; m_rptr = BEG; m_wpend = 1'b0; m_rpend = 1'b0;
      return;
    end
    wdn = (m_owner == 0) && !m_first && wr_done;
    rdn = (m_owner == 1) && !m_first && rd_done;
    if (wdn) begin
      m_wptr  = (wr_addr_clr || m_wpend) ? BEG : advance(m_wptr);
      m_wpend = 1'b0;
    end else if (wr_addr_clr) begin
      if (m_owner == 0) m_wpend = 1'b1;
      else              m_wptr  = BEG;
    end
    if (rdn) begin
      m_rptr  = (rd_addr_clr || m_rpend) ? BEG : advance(m_rptr);
      m_rpend = 1'b0;
    end else if (rd_addr_clr) begin
      if (m_owner == 1) m_rpend = 1'b1;
      else              m_rptr  = BEG;
    end
    if (m_owner < 0) begin
      wv = wr_req && wr_ready;
      rv = rd_req && rd_ready;
      g  = -1;
      if (wv && rv)  g = RD_PRIO ? 1 : ((m_last == 0) ? 1 : 0);
      else if (wv)   g = 0;
      else if (rv)   g = 1;
      if (g >= 0) begin
        m_owner = g; m_first = 1'b1; m_last = g;
      end
    end else if (m_first) begin
      m_first = 1'b0;
    end else if (wdn || rdn) begin
      m_owner = -1;
    end
  endtask

  // One clock: advance the model on the edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("m_wr_start", wr_start, (m_owner == 0 && m_first) ? 1 : 0);
    chk("m_rd_start", rd_start, (m_owner == 1 && m_first) ? 1 : 0);
    chk("m_busy", busy, (m_owner >= 0) ? 1 : 0);
    chk("m_wr_addr", wr_addr, m_wptr);
    chk("m_rd_addr", rd_addr, m_rptr);
    chk("m_wr_len", wr_len, 255);
    chk("m_rd_len", rd_len, 255);
  endtask

  task automatic clear_inputs();
    rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_addr_clr = 1'b0; rd_addr_clr = 1'b0;
    wr_done = 1'b0; rd_done = 1'b0; wr_ready = 1'b1; rd_ready = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_start(input string nm, output bit ok);
    int budget;
    budget = 0;
    ok = 1'b0;
    while (!ok && budget < 20) begin
      tick();
      budget++;
      ok = wr_start || rd_start;
    end
    if (!ok) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic run_burst(input int dir, input longint exp_addr, input string nm);
    bit ok;
    if (dir == 0) wr_req = 1'b1; else rd_req = 1'b1;
    wait_start(nm, ok);
    if (ok) begin
      chk({nm, "_dir"}, rd_start ? 1 : 0, dir);
      chk({nm, "_addr"}, (dir == 0) ? wr_addr : rd_addr, exp_addr);
    end
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (3) tick();
    if (dir == 0) wr_done = 1'b1; else rd_done = 1'b1;
    tick();
    wr_done = 1'b0; rd_done = 1'b0;
  endtask

  typedef struct {
    bit rst, wq, rq, wy, ry, wd, rdn, wc, rc;
    bit ews, ers, eb;
    int ewa, era;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit wq, input bit rq, input bit wy, input bit ry,
                              input bit wd, input bit rdn, input bit wc, input bit rc,
                              input bit ews, input bit ers, input bit eb, input int ewa, input int era);
    vec_t v;
    v.rst = r; v.wq = wq; v.rq = rq; v.wy = wy; v.ry = ry; v.wd = wd; v.rdn = rdn;
    v.wc = wc; v.rc = rc; v.ews = ews; v.ers = ers; v.eb = eb; v.ewa = ewa; v.era = era;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    bit ok;
    int exp_grant[4];
    longint wrap_exp[5];

    clear_inputs();
    //           rst wq rq wy ry wd rd wc rc | ws rs b   wa    ra
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,    0,    0);
    tbl[1]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0,    0,    0);
    tbl[2]  = mk(0, 1, 0, 1, 1, 0, 0, 0, 0,   1, 0, 1,    0,    0);
    tbl[3]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 1,    0,    0);
    tbl[4]  = mk(0, 0, 0, 1, 1, 1, 0, 0, 0,   0, 0, 0, 2048,    0);
    tbl[5]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 2048,    0);
    tbl[6]  = mk(0, 1, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 2048,    0);
    tbl[7]  = mk(0, 1, 0, 1, 1, 0, 0, 0, 0,   1, 0, 1, 2048,    0);
    tbl[8]  = mk(0, 0, 0, 1, 1, 0, 1, 0, 0,   0, 0, 1, 2048,    0);
    tbl[9]  = mk(0, 0, 0, 1, 1, 1, 0, 0, 0,   0, 0, 0, 4096,    0);
    tbl[10] = mk(0, 1, 1, 1, 1, 0, 0, 0, 0,   0, 1, 1, 4096,    0);
    tbl[11] = mk(0, 0, 0, 1, 1, 0, 0, 0, 1,   0, 0, 1, 4096,    0);
    tbl[12] = mk(0, 0, 0, 1, 1, 0, 1, 0, 0,   0, 0, 0, 4096,    0);
    tbl[13] = mk(0, 0, 0, 1, 1, 0, 0, 1, 0,   0, 0, 0,    0,    0);
    tbl[14] = mk(0, 1, 0, 1, 1, 0, 0, 0, 0,   1, 0, 1,    0,    0);
    tbl[15] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 1,    0,    0);
    tbl[16] = mk(0, 0, 0, 1, 1, 1, 0, 0, 0,   0, 0, 0, 2048,    0);
    tbl[17] = mk(0, 1, 0, 1, 1, 0, 0, 0, 0,   1, 0, 1, 2048,    0);
    tbl[18] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 1, 2048,    0);
    tbl[19] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0,    0,    0);

    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].rst; wr_req = tbl[i].wq; rd_req = tbl[i].rq;
      wr_ready = tbl[i].wy; rd_ready = tbl[i].ry;
      wr_done = tbl[i].wd; rd_done = tbl[i].rdn;
      wr_addr_clr = tbl[i].wc; rd_addr_clr = tbl[i].rc;
      tick();
      chk($sformatf("vec%0d_wr_start", i), wr_start, tbl[i].ews);
      chk($sformatf("vec%0d_rd_start", i), rd_start, tbl[i].ers);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("vec%0d_wr_addr", i), wr_addr, tbl[i].ewa);
      chk($sformatf("vec%0d_rd_addr", i), rd_addr, tbl[i].era);
    end

    // Wrap: five write bursts inside an 8 KiB region.
    do_reset();
    wrap_exp[0] = 0; wrap_exp[1] = 2048; wrap_exp[2] = 4096; wrap_exp[3] = 6144; wrap_exp[4] = 0;
    for (int k = 0; k < 5; k++) run_burst(0, wrap_exp[k], $sformatf("wrap%0d", k));

    // Tie: both requesters held high.
    do_reset();
    if (RD_PRIO) begin
      exp_grant[0] = 1; exp_grant[1] = 1; exp_grant[2] = 1; exp_grant[3] = 1;
    end else begin
      exp_grant[0] = 1; exp_grant[1] = 0; exp_grant[2] = 1; exp_grant[3] = 0;
    end
    wr_req = 1'b1; rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_start($sformatf("tie%0d", k), ok);
      if (ok) begin
        chk($sformatf("tie%0d_grant", k), rd_start ? 1 : 0, exp_grant[k]);
        tick(); tick();
        if (rd_start || busy) begin
          if (m_owner == 1) rd_done = 1'b1; else wr_done = 1'b1;
        end
        tick();
        wr_done = 1'b0; rd_done = 1'b0;
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    tick();

    // Clear mid-burst on the read side at address 4096.
    do_reset();
    run_burst(1, 0, "clr_pre0");
    run_burst(1, 2048, "clr_pre1");
    rd_req = 1'b1;
    wait_start("clr_mid", ok);
    chk("clr_mid_start_addr", rd_addr, 4096);
    rd_req = 1'b0;
    tick();
    rd_addr_clr = 1'b1;
    tick();
    rd_addr_clr = 1'b0;
    chk("clr_mid_held_addr", rd_addr, 4096);
    tick();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("clr_mid_after_done", rd_addr, 0);

    // Ready gating: request with the write master not ready.
    do_reset();
    wr_ready = 1'b0; wr_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("gate%0d_no_start", k), wr_start, 0);
    end
    wr_ready = 1'b1;
    tick();
    chk("gate_start", wr_start, 1);
    wr_req = 1'b0;
    tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst         = ($urandom_range(0, 199) == 0);
      wr_req      = ($urandom_range(0, 2) != 0);
      rd_req      = ($urandom_range(0, 2) != 0);
      wr_ready    = ($urandom_range(0, 3) != 0);
      rd_ready    = ($urandom_range(0, 3) != 0);
      wr_done     = ($urandom_range(0, 4) == 0);
      rd_done     = ($urandom_range(0, 4) == 0);
      wr_addr_clr = ($urandom_range(0, 29) == 0);
      rd_addr_clr = ($urandom_range(0, 29) == 0);
      tick();
    end
    clear_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
